// File: rtl/udp_tx_arbiter_pkg.sv
// Shared types and constants for the UDP TX frame arbiter.
// Optional build macro: UDP_TX_ARBITER_STATS_EN (per-port frame counters).
package udp_tx_arbiter_pkg;

   localparam int UDP_TX_ARB_MAX_PORTS = 8;
   localparam int UDP_TX_ARB_COUNT_W   = 16;

   // AXI-Stream sideband widths used by the payload interface
   localparam int UDP_TX_ARB_DATA_W = 8;
   localparam int UDP_TX_ARB_KEEP_W = 1;
   localparam int UDP_TX_ARB_ID_W   = 8;
   localparam int UDP_TX_ARB_DEST_W = 8;
   localparam int UDP_TX_ARB_USER_W = 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HDR     = 2'd1,
      PAYLOAD = 2'd2
   } udp_tx_arbiter_state_t;

   typedef struct packed {
      logic [31:0] src_ip;
      logic [31:0] dst_ip;
      logic [15:0] src_port;
      logic [15:0] dst_port;
      logic [15:0] length;
      logic [15:0] checksum;
   } udp_hdr_t;

   typedef struct packed {
      logic [UDP_TX_ARB_DATA_W-1:0] tdata;
      logic [UDP_TX_ARB_KEEP_W-1:0] tkeep;
      logic                         tlast;
      logic [UDP_TX_ARB_ID_W-1:0]   tid;
      logic [UDP_TX_ARB_DEST_W-1:0] tdest;
      logic [UDP_TX_ARB_USER_W-1:0] tuser;
   } axis_beat_t;

   // Width of a port index; never less than one bit
   function automatic int udp_tx_arb_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/udp_tx_arbiter_if.sv
// Header and payload interfaces used by the UDP TX arbiter.
// Handshake rule for both: a transfer happens on a clock edge where
// valid and ready are both high; the source holds valid and its data
// stable until that edge, and ready may depend combinationally on valid.
interface udp_header_interface;
   logic        udp_hdr_valid;
   logic        udp_hdr_ready;
   logic [31:0] src_ip;
   logic [31:0] dst_ip;
   logic [15:0] src_port;
   logic [15:0] dst_port;
   logic [15:0] length;
   logic [15:0] checksum;

   modport Output (output udp_hdr_valid, src_ip, dst_ip, src_port, dst_port, length, checksum,
                   input  udp_hdr_ready);
   modport Input  (input  udp_hdr_valid, src_ip, dst_ip, src_port, dst_port, length, checksum,
                   output udp_hdr_ready);
endinterface

interface axis_interface;
   import udp_tx_arbiter_pkg::*;
   logic [UDP_TX_ARB_DATA_W-1:0] tdata;
   logic [UDP_TX_ARB_KEEP_W-1:0] tkeep;
   logic                         tvalid;
   logic                         tready;
   logic                         tlast;
   logic [UDP_TX_ARB_ID_W-1:0]   tid;
   logic [UDP_TX_ARB_DEST_W-1:0] tdest;
   logic [UDP_TX_ARB_USER_W-1:0] tuser;

   modport Source (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
   modport Sink   (input  tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/udp_tx_arbiter_rr_select.sv
// Combinational round-robin pick: first requesting port strictly after
// last_grant, wrapping from NUM_PORTS-1 back to 0.
module rr_select
   import udp_tx_arbiter_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int IDX_W     = udp_tx_arb_idx_w(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IDX_W-1:0]     last_grant,
   output logic [NUM_PORTS-1:0] sel,
   output logic [IDX_W-1:0]     sel_idx,
   output logic                 any_req
);

   logic [IDX_W-1:0] cand;

   // walk the ports in priority order, the just-served port being visited last
   always_comb begin
      sel     = '0;
      sel_idx = '0;
      any_req = 1'b0;
      cand    = last_grant;
      for (int off = 0; off < NUM_PORTS; off++) begin
         if (cand == IDX_W'(NUM_PORTS - 1)) cand = '0;
         else                               cand = cand + 1'b1;
         if (!any_req && req[cand]) begin
            any_req   = 1'b1;
            sel[cand] = 1'b1;
            sel_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/udp_tx_arbiter.sv
// Frame-level round-robin arbiter sharing one UDP TX path.
// A granted port sends its header, then its payload through tlast;
// ready signals pass straight through, nothing is buffered here.
// Optional build macro: UDP_TX_ARBITER_STATS_EN adds frame_count.
module udp_tx_arbiter
   import udp_tx_arbiter_pkg::*;
#(
   parameter int NUM_PORTS = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   udp_header_interface.Input          udp_in [NUM_PORTS],
   axis_interface.Sink                 axis_in [NUM_PORTS],
   udp_header_interface.Output         udp_out,
   axis_interface.Source               axis_out,
   input  logic                        downstream_busy,
   output logic [NUM_PORTS-1:0]        grant,
   output logic                        active,
   output udp_tx_arbiter_state_t       fsm_state
`ifdef UDP_TX_ARBITER_STATS_EN
   ,
   output logic [UDP_TX_ARB_COUNT_W-1:0] frame_count [NUM_PORTS]
`endif
);

   localparam int IDX_W = udp_tx_arb_idx_w(NUM_PORTS);

   udp_tx_arbiter_state_t state;
   logic [IDX_W-1:0]      sel_idx;
   logic [IDX_W-1:0]      last_grant;

   logic [NUM_PORTS-1:0]  req;
   logic [NUM_PORTS-1:0]  pick_onehot;
   logic [IDX_W-1:0]      pick_idx;
   logic                  any_req;

   udp_hdr_t              hdr_in     [NUM_PORTS];
   axis_beat_t            beat_in    [NUM_PORTS];
   logic [NUM_PORTS-1:0]  beat_valid;
   udp_hdr_t              hdr_sel;
   axis_beat_t            beat_sel;

   logic                  hdr_valid;
   logic                  pay_valid;
   logic                  hdr_fire;
   logic                  beat_fire;
   logic                  frame_done;

   assign fsm_state = state;

   // flatten the interface arrays so the owner can be picked by a run-time index
   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
      assign req[g]        = udp_in[g].udp_hdr_valid;
      assign beat_valid[g] = axis_in[g].tvalid;
      assign hdr_in[g] = '{src_ip:   udp_in[g].src_ip,
                           dst_ip:   udp_in[g].dst_ip,
                           src_port: udp_in[g].src_port,
                           dst_port: udp_in[g].dst_port,
                           length:   udp_in[g].length,
                           checksum: udp_in[g].checksum};
      assign beat_in[g] = '{tdata: axis_in[g].tdata,
                            tkeep: axis_in[g].tkeep,
                            tlast: axis_in[g].tlast,
                            tid:   axis_in[g].tid,
                            tdest: axis_in[g].tdest,
                            tuser: axis_in[g].tuser};
      // only the owner ever sees a ready, and only in the matching phase
      assign udp_in[g].udp_hdr_ready = (state == HDR) && grant[g] && udp_out.udp_hdr_ready;
      assign axis_in[g].tready       = (state == PAYLOAD) && grant[g] && axis_out.tready;
   end

   rr_select #(
      .NUM_PORTS (NUM_PORTS),
      .IDX_W     (IDX_W)
   ) u_rr_select (
      .req        (req),
      .last_grant (last_grant),
      .sel        (pick_onehot),
      .sel_idx    (pick_idx),
      .any_req    (any_req)
   );

   assign hdr_sel  = hdr_in[sel_idx];
   assign beat_sel = beat_in[sel_idx];

   assign hdr_valid  = (state == HDR) && req[sel_idx];
   assign pay_valid  = (state == PAYLOAD) && beat_valid[sel_idx];
   assign hdr_fire   = hdr_valid && udp_out.udp_hdr_ready;
   assign beat_fire  = pay_valid && axis_out.tready;
   assign frame_done = beat_fire && beat_sel.tlast;

   assign udp_out.udp_hdr_valid = hdr_valid;
   assign udp_out.src_ip        = hdr_sel.src_ip;
   assign udp_out.dst_ip        = hdr_sel.dst_ip;
   assign udp_out.src_port      = hdr_sel.src_port;
   assign udp_out.dst_port      = hdr_sel.dst_port;
   assign udp_out.length        = hdr_sel.length;
   assign udp_out.checksum      = hdr_sel.checksum;

   assign axis_out.tvalid = pay_valid;
   assign axis_out.tdata  = beat_sel.tdata;
   assign axis_out.tkeep  = beat_sel.tkeep;
   assign axis_out.tlast  = beat_sel.tlast;
   assign axis_out.tid    = beat_sel.tid;
   assign axis_out.tdest  = beat_sel.tdest;
   assign axis_out.tuser  = beat_sel.tuser;

   // frame ownership FSM; busy only gates the choice made in IDLE
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         grant      <= '0;
         active     <= 1'b0;
         sel_idx    <= '0;
         last_grant <= IDX_W'(NUM_PORTS - 1);
      end else begin
         case (state)
            IDLE: begin
               if (any_req && !downstream_busy) begin
                  grant   <= pick_onehot;
                  sel_idx <= pick_idx;
                  active  <= 1'b1;
                  state   <= HDR;
               end
            end
            HDR: begin
               if (hdr_fire) state <= PAYLOAD;
            end
            PAYLOAD: begin
               if (frame_done) begin
                  last_grant <= sel_idx;
                  grant      <= '0;
                  active     <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: begin
               grant  <= '0;
               active <= 1'b0;
               state  <= IDLE;
            end
         endcase
      end
   end

`ifdef UDP_TX_ARBITER_STATS_EN
   // completed-frame counters, one per port, wrapping at full scale
   always_ff @(posedge clk) begin
      if (reset) begin
         frame_count <= '{default: '0};
      end else if (state == PAYLOAD && frame_done) begin
         frame_count[sel_idx] <= frame_count[sel_idx] + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Bench for udp_tx_arbiter with two requesters.
// Optional build macro: UDP_TX_ARBITER_STATS_EN enables the counter checks.
module tb_udp_tx_arbiter;
  import udp_tx_arbiter_pkg::*;

  localparam int N = 2;
  localparam int CYC_LIMIT = 400;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic downstream_busy = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] grant;
  logic active;
  udp_tx_arbiter_state_t fsm_state;
`ifdef UDP_TX_ARBITER_STATS_EN
  logic [UDP_TX_ARB_COUNT_W-1:0] frame_count [N];
`endif

  // per-port source side
  logic       h_valid [N];
  udp_hdr_t   h_data  [N];
  logic       h_ready [N];
  logic       a_valid [N];
  logic [7:0] a_data  [N];
  logic       a_last  [N];
  logic       a_ready [N];
  logic       out_hdr_ready = 1'b1;
  logic       out_tready = 1'b1;
  bit         bp_en = 1'b0;

  udp_header_interface udp_in_if [N] ();
  axis_interface       axis_in_if [N] ();
  udp_header_interface udp_out_if ();
  axis_interface       axis_out_if ();

  for (genvar g = 0; g < N; g++) begin : g_tb
    assign udp_in_if[g].udp_hdr_valid = h_valid[g];
    assign udp_in_if[g].src_ip   = h_data[g].src_ip;
    assign udp_in_if[g].dst_ip   = h_data[g].dst_ip;
    assign udp_in_if[g].src_port = h_data[g].src_port;
    assign udp_in_if[g].dst_port = h_data[g].dst_port;
    assign udp_in_if[g].length   = h_data[g].length;
    assign udp_in_if[g].checksum = h_data[g].checksum;
    assign h_ready[g] = udp_in_if[g].udp_hdr_ready;
    assign axis_in_if[g].tvalid = a_valid[g];
    assign axis_in_if[g].tdata  = a_data[g];
    assign axis_in_if[g].tlast  = a_last[g];
    assign axis_in_if[g].tkeep  = 1'b1;
    assign axis_in_if[g].tid    = 8'(g);
    assign axis_in_if[g].tdest  = 8'(g + 8'h10);
    assign axis_in_if[g].tuser  = 1'b0;
    assign a_ready[g] = axis_in_if[g].tready;
  end
  assign udp_out_if.udp_hdr_ready = out_hdr_ready;
  assign axis_out_if.tready = out_tready;

  udp_tx_arbiter #(.NUM_PORTS(N)) dut (
    .clk             (clk),
    .reset           (reset),
    .udp_in          (udp_in_if),
    .axis_in         (axis_in_if),
    .udp_out         (udp_out_if),
    .axis_out        (axis_out_if),
    .downstream_busy (downstream_busy),
    .grant           (grant),
    .active          (active),
    .fsm_state       (fsm_state)
`ifdef UDP_TX_ARBITER_STATS_EN
    ,
    .frame_count     (frame_count)
`endif
  );

  // random downstream back-pressure when enabled
  always @(posedge clk) begin
    #1;
    out_tready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int frames_done = 0;
  int rst_epoch = 0;
  int beats_acc [N];
  int done_order [$];
  logic [8:0] exp_q0 [$];
  logic [8:0] exp_q1 [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound of %0d cycles expired at %0t", name, CYC_LIMIT, $time);
  endtask

  task automatic at_sample();
    @(negedge clk);
    #1;
  endtask

  function automatic udp_hdr_t mk_hdr(input int p, input int k);
    udp_hdr_t h;
    h.src_ip   = 32'hC0A80100 + 32'(p);
    h.dst_ip   = 32'h0A000000 + 32'(k);
    h.src_port = 16'(4000 + p);
    h.dst_port = 16'(5000 + k);
    h.length   = 16'(8 + k);
    h.checksum = 16'(k * 3 + p);
    return h;
  endfunction

  // ---------------- behavioural model + compare ----------------
  function automatic int rr_pick(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (((req >> c) & 1) != 0) return c;
    end
    return -1;
  endfunction

  int   m_owner = -1;
  int   m_phase = 0;      // 0 = header pending, 1 = payload
  int   m_last = N - 1;
  logic [N-1:0] p_req = '0;
  bit   p_busy = 1'b0, p_reset = 1'b1, p_hdr_fire = 1'b0, p_beat_fire = 1'b0, p_beat_last = 1'b0;

  always @(negedge clk) begin : compare
    logic [N-1:0] e_grant;
    bit e_hv, e_tv;
    udp_tx_arbiter_state_t e_state;
    udp_hdr_t act_h;
    logic [8:0] e_beat;

    // advance the model over the clock edge that just happened
    if (p_reset) begin
      m_owner = -1; m_phase = 0; m_last = N - 1;
    end else if (m_owner < 0) begin
      if (!p_busy && p_req != '0) begin
        m_owner = rr_pick(p_req, m_last);
        m_phase = 0;
      end
    end else if (m_phase == 0) begin
      if (p_hdr_fire) m_phase = 1;
    end else if (p_beat_fire && p_beat_last) begin
      m_last = m_owner;
      done_order.push_back(m_owner);
      m_owner = -1;
    end

    e_grant = (m_owner < 0) ? '0 : N'(1 << m_owner);
    e_state = (m_owner < 0) ? IDLE : ((m_phase == 0) ? HDR : PAYLOAD);
    e_hv = 1'b0;
    e_tv = 1'b0;
    if (m_owner >= 0) begin
      e_hv = (m_phase == 0) && h_valid[m_owner];
      e_tv = (m_phase == 1) && a_valid[m_owner];
    end

    check("grant", grant, e_grant);
    check("active", active, m_owner >= 0);
    check("fsm_state", fsm_state, e_state);
    check("hdr_valid", udp_out_if.udp_hdr_valid, e_hv);
    check("tvalid", axis_out_if.tvalid, e_tv);
    for (int p = 0; p < N; p++) begin
      check("hdr_ready_port", h_ready[p], (p == m_owner && m_phase == 0) ? out_hdr_ready : 1'b0);
      check("tready_port", a_ready[p], (p == m_owner && m_phase == 1) ? out_tready : 1'b0);
    end

    if (e_hv) begin
      act_h = '{src_ip: udp_out_if.src_ip, dst_ip: udp_out_if.dst_ip,
                src_port: udp_out_if.src_port, dst_port: udp_out_if.dst_port,
                length: udp_out_if.length, checksum: udp_out_if.checksum};
      check("hdr_fields", act_h, h_data[m_owner]);
    end
    if (e_tv) begin
      check("beat_sideband", {axis_out_if.tid, axis_out_if.tdest, axis_out_if.tkeep, axis_out_if.tuser},
            {8'(m_owner), 8'(m_owner + 8'h10), 1'b1, 1'b0});
      if (out_tready) begin
        // scoreboard: accepted beats must match the owner's queue in order
        if ((m_owner == 0 && exp_q0.size() == 0) || (m_owner == 1 && exp_q1.size() == 0)) begin
          check("sb_underflow", {axis_out_if.tlast, axis_out_if.tdata}, 9'h1ff);
        end else begin
          e_beat = (m_owner == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
          check("sb_beat", {axis_out_if.tlast, axis_out_if.tdata}, e_beat);
        end
        beats_acc[m_owner]++;
      end
    end

    p_req = '0;
    for (int p = 0; p < N; p++) p_req[p] = h_valid[p];
    p_busy      = downstream_busy;
    p_reset     = reset;
    p_hdr_fire  = e_hv && out_hdr_ready;
    p_beat_fire = e_tv && out_tready;
    p_beat_last = e_tv ? a_last[m_owner] : 1'b0;
  end

  // ---------------- driver tasks ----------------
  task automatic send_frame(input int p, input udp_hdr_t h, input int n, input logic [7:0] base);
    int epoch, t;
    bit ok;
    epoch = rst_epoch;
    for (int b = 0; b < n; b++) begin
      if (p == 0) exp_q0.push_back({(b == n - 1), 8'(base + b)});
      else        exp_q1.push_back({(b == n - 1), 8'(base + b)});
    end
    h_data[p] = h;
    h_valid[p] = 1'b1;
    t = 0; ok = 1'b0;
    while (!ok) begin
      @(negedge clk);
      if (epoch != rst_epoch) return;
      if (h_ready[p]) ok = 1'b1;
      else if (++t > CYC_LIMIT) begin timeout_fail("hdr_accept"); h_valid[p] = 1'b0; return; end
    end
    @(posedge clk); #1;
    h_valid[p] = 1'b0;
    for (int b = 0; b < n; b++) begin
      a_data[p] = 8'(base + b);
      a_last[p] = (b == n - 1);
      a_valid[p] = 1'b1;
      t = 0; ok = 1'b0;
      while (!ok) begin
        @(negedge clk);
        if (epoch != rst_epoch) return;
        if (a_ready[p]) ok = 1'b1;
        else if (++t > CYC_LIMIT) begin timeout_fail("beat_accept"); a_valid[p] = 1'b0; return; end
      end
      @(posedge clk); #1;
    end
    a_valid[p] = 1'b0;
    a_last[p] = 1'b0;
    frames_done++;
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (frames_done < target) begin
      @(negedge clk);
      if (++t > CYC_LIMIT * 4) begin timeout_fail("frames_done"); return; end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    rst_epoch++;
    for (int p = 0; p < N; p++) begin h_valid[p] = 1'b0; a_valid[p] = 1'b0; a_last[p] = 1'b0; end
    exp_q0.delete();
    exp_q1.delete();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_grant"}, grant, 2'b00);
    check({tag, "_active"}, active, 1'b0);
    check({tag, "_hdr_valid"}, udp_out_if.udp_hdr_valid, 1'b0);
    check({tag, "_tvalid"}, axis_out_if.tvalid, 1'b0);
    check({tag, "_readies"}, {h_ready[1], h_ready[0], a_ready[1], a_ready[0]}, 4'b0000);
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    int n, base_done, base_ord, b1;
    udp_hdr_t hdr1;
    for (int p = 0; p < N; p++) begin
      h_valid[p] = 1'b0; a_valid[p] = 1'b0; a_last[p] = 1'b0; a_data[p] = '0;
      h_data[p] = '0; beats_acc[p] = 0;
    end

    // reset state
    repeat (3) @(posedge clk);
    at_sample();
    check_quiet("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // single requester, one-beat payload
    hdr1 = '{src_ip: 32'hC0A80180, dst_ip: 32'hC0A8017F, src_port: 16'd3001,
             dst_port: 16'd3000, length: 16'd1, checksum: 16'h0000};
    @(posedge clk); #1;
    fork send_frame(0, hdr1, 1, 8'h00); join_none
    n = 0;
    do begin at_sample(); n++; end while (!udp_out_if.udp_hdr_valid && n < 20);
    check("single_latency", n, 2);
    check("single_grant", grant, 2'b01);
    check("single_src_ip", udp_out_if.src_ip, 32'hC0A80180);
    check("single_dst_ip", udp_out_if.dst_ip, 32'hC0A8017F);
    check("single_ports", {udp_out_if.src_port, udp_out_if.dst_port}, {16'd3001, 16'd3000});
    check("single_length", udp_out_if.length, 16'd1);
    wait_done(1);
    check("single_beats", beats_acc[0], 1);

    // contention: reset restores port 0 as first winner
    do_reset();
    base_ord = done_order.size();
    @(posedge clk); #1;
    fork
      begin send_frame(0, mk_hdr(0, 1), 3, 8'h10); send_frame(0, mk_hdr(0, 2), 2, 8'h20); end
      send_frame(1, mk_hdr(1, 1), 4, 8'h30);
    join_none
    wait_done(4);
    at_sample();
    check("contention_count", done_order.size() - base_ord, 3);
    if (done_order.size() - base_ord >= 3)
      check("contention_order", {4'(done_order[base_ord]), 4'(done_order[base_ord + 1]), 4'(done_order[base_ord + 2])},
            12'h010);

    // back-pressure on a 16-beat payload while the other port waits
    b1 = beats_acc[0];
    bp_en = 1'b1;
    @(posedge clk); #1;
    fork
      send_frame(0, mk_hdr(0, 3), 16, 8'h40);
      begin send_frame(1, mk_hdr(1, 2), 2, 8'h80); send_frame(1, mk_hdr(1, 3), 2, 8'h90); end
    join_none
    wait_done(7);
    bp_en = 1'b0;
    at_sample();
    check("bp_beats_port0", beats_acc[0] - b1, 16);

    // busy gating: last winner is port 1, so port 1 alone is the request
    @(posedge clk); #1;
    downstream_busy = 1'b1;
    fork send_frame(1, mk_hdr(1, 4), 2, 8'hA0); join_none
    repeat (5) begin at_sample(); check("busy_grant_held", grant, 2'b00); end
    @(posedge clk); #1;
    downstream_busy = 1'b0;
    at_sample();
    check("busy_release_edge", grant, 2'b00);
    at_sample();
    check("busy_grant_after", grant, 2'b10);
    wait_done(8);

    // single-beat frame from port 0, then port 1 is reset mid-payload
    @(posedge clk); #1;
    send_frame(0, mk_hdr(0, 5), 1, 8'hB0);
    b1 = beats_acc[1];
    fork send_frame(1, mk_hdr(1, 5), 8, 8'hC0); join_none
    n = 0;
    while (beats_acc[1] - b1 < 3 && n < CYC_LIMIT) begin at_sample(); n++; end
    if (n >= CYC_LIMIT) timeout_fail("reset_mid_wait");
    do_reset();
    at_sample();
    check_quiet("mid_reset");
    check("mid_reset_beats", beats_acc[1] - b1, 3);
    base_done = frames_done;
    @(posedge clk); #1;
    fork send_frame(0, mk_hdr(0, 6), 1, 8'hD0); send_frame(1, mk_hdr(1, 6), 1, 8'hE0); join_none
    n = 0;
    while (grant == 2'b00 && n < 20) begin at_sample(); n++; end
    check("post_reset_grant", grant, 2'b01);
    wait_done(base_done + 2);

`ifdef UDP_TX_ARBITER_STATS_EN
    do_reset();
    at_sample();
    check("stats_cleared", {frame_count[1], frame_count[0]}, 32'h0);
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) send_frame(1, mk_hdr(1, 7 + k), 2, 8'(8'h50 + 8'(k * 4)));
    at_sample();
    check("stats_port1", frame_count[1], 16'd3);
    check("stats_port0", frame_count[0], 16'd0);
`endif

    repeat (3) at_sample();
    check("sb_drained", exp_q0.size() + exp_q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // global bound in case a wait escapes its own limit
  initial begin
    #400000;
    errors++;
    checks++;
    $display("FAIL global_timeout: simulation did not complete at %0t", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/udp_tx_arbiter.md
# udp_tx_arbiter

Frame-level round-robin arbiter that shares one UDP transmit path between several requesters. Each requester presents a UDP header plus an AXI-Stream payload. The arbiter grants one requester at a time and forwards its header and then its payload, through tlast, into `udp_checksum_gen_wrapper`. It sits between the application-side UDP sources and the checksum generator / UDP TX stack.

## Interface
Parameters:
- `NUM_PORTS`, default 2: number of requesters, range 2..8.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock for all logic.
- `reset` in 1: synchronous, active-high.
- `udp_in[NUM_PORTS]` in, `udp_header_interface.Input`: requester headers.
- `axis_in[NUM_PORTS]` in, `axis_interface.Sink`: requester payloads.
- `udp_out` out, `udp_header_interface.Output`: header to the checksum generator.
- `axis_out` out, `axis_interface.Source`: payload to the checksum generator.
- `downstream_busy` in 1: `busy` from the checksum generator; blocks new grants.
- `grant` out NUM_PORTS: one-hot index of the current owner; 0 when idle.
- `active` out 1: high while a frame is owned (states HDR or PAYLOAD).

## Operation
- State machine `IDLE -> HDR -> PAYLOAD -> IDLE`.
- **IDLE:**
  - A request from port i is `udp_in[i].udp_hdr_valid`.
  - If any request is present and `downstream_busy` is 0, select the first requesting port after `last_grant` in round-robin order. Register it into `grant` and move to HDR.
  - All ready signals are 0. `udp_out.udp_hdr_valid` and `axis_out.tvalid` are 0.
- **HDR:**
  - All `udp_out` header fields, including `udp_hdr_valid`, come from the selected port.
  - `udp_in[sel].udp_hdr_ready` is driven from `udp_out.udp_hdr_ready`.
  - When `udp_out.udp_hdr_valid && udp_out.udp_hdr_ready`, move to PAYLOAD.
  - No payload is forwarded in HDR: `axis_out.tvalid` = 0 and all `axis_in[*].tready` = 0.
- **PAYLOAD:**
  - `axis_out` tdata, tkeep, tlast, tid, tdest, tuser and tvalid come from `axis_in[sel]`.
  - `axis_in[sel].tready` is driven from `axis_out.tready`.
  - On `tvalid && tready && tlast`, set `last_grant <= sel`, clear `grant` and move to IDLE.
- Non-selected ports always see `udp_hdr_ready` = 0 and `tready` = 0.
- A requester must hold `udp_hdr_valid` and its header fields stable until accepted. The arbiter never aborts a frame and has no timeout.
- Downstream `udp_hdr_ready` and `tready` pass through combinationally to the selected requester. There is no buffering inside the arbiter.

## Timing
- Reset values:
  - state = IDLE.
  - `grant` = 0, `active` = 0.
  - `last_grant` = NUM_PORTS-1, so port 0 wins first.
  - All output valid signals are 0 and all input ready signals are 0.
- Grant latency: a request seen in IDLE gives `udp_out.udp_hdr_valid` = 1 on the next cycle.
- Header-to-payload: the payload can be forwarded starting the cycle after the header handshake.
- Inter-frame gap: at least 1 IDLE cycle between the tlast beat and the next header, including when requests are pending at tlast.
- `downstream_busy` is sampled only in IDLE; it has no effect once a frame is owned.
- Simultaneous requests: round-robin order strictly after `last_grant`, wrapping from NUM_PORTS-1 to 0. A port that just finished has the lowest priority.
- Single-beat payload (tlast on the first beat): PAYLOAD lasts exactly 1 accepted beat.
- Reset mid-frame: on the next clock the arbiter returns to IDLE and clears all outputs. The partial frame is abandoned, and upstream/downstream must be reset together.

## Configuration
- Macro `UDP_TX_ARBITER_STATS_EN`.
- Defined:
  - Adds output `frame_count[NUM_PORTS]`, 16 bits each.
  - A port's counter increments on each accepted tlast beat from that port, wraps at 0xFFFF -> 0, and is cleared by reset.
- Undefined: the port and the counters are absent and all other behaviour is identical.

## Structure
- Package `udp_tx_arbiter_pkg`:
  - `udp_tx_arbiter_state_t` enum (IDLE, HDR, PAYLOAD).
  - `UDP_TX_ARB_MAX_PORTS` = 8.
  - `UDP_TX_ARB_COUNT_W` = 16.
- Sub-module `rr_select`: combinational round-robin pick. Inputs are the request vector and `last_grant`; outputs are a one-hot select and a `any_req` flag.
- Header and AXIS muxing, the FSM and the counters live in the top module.

## Test plan
- **Single requester:** port 0 sends a header (src 192.168.1.128:3001, dst 192.168.1.127:3000, length 1) and payload 0x00 with tlast. Required response:
  - `grant` = 2'b01.
  - `udp_out` fields match the input.
  - one payload beat is forwarded.
  - with the wrapper in the path, the checksum is 0x641b.
- **Contention:** ports 0 and 1 request together in the same cycle. Required order is 0 then 1 then 0, with at least 1 IDLE cycle between frames and no interleaving of beats.
- **Back-pressure:** toggle `axis_out.tready` randomly during a 16-beat payload. All 16 beats arrive in order, and the non-selected port's tready stays at 0.
- **Busy gating:** hold `downstream_busy` = 1 for 5 cycles while port 1 requests. `grant` stays 0 for those 5 cycles and is asserted 1 cycle after busy falls.
- **Reset mid-payload:** assert reset for 1 cycle at beat 3 of 8. On the next cycle all valid and ready signals and `grant` are 0. The next grant goes to port 0.
- **Statistics (with `UDP_TX_ARBITER_STATS_EN`):** send 3 frames from port 1. `frame_count[1]` = 3 and `frame_count[0]` = 0.
